// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a 2-flop input synchronizer.
// The start bit is confirmed at its midpoint. Each data bit and the stop bit are
// then sampled one full bit period apart, so every sample lands mid-bit.
// The FSM returns to IDLE at mid-stop, so a start bit that follows the stop bit
// with no idle gap is still detected.
// Handshake: rx_valid is a one-cycle strobe with no back-pressure. rx_data holds
// the last good byte and changes only on the cycle that rx_valid is high.
// frame_err is a one-cycle strobe for a stop bit sampled low. rx_valid and
// frame_err are never high in the same cycle.
module uart_rx #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy,
    output logic [2:0] state_dbg_o
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

    logic          sync1_q;
    logic          sync2_q;
    logic          rx_s;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic [7:0]    rx_data_q;
    logic          rx_valid_q;
    logic          frame_err_q;
    logic          busy_q;

    assign rx_s = sync2_q;

    // Two-flop synchronizer for the asynchronous line; resets to the idle (high) level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_in;
            sync2_q <= sync1_q;
        end
    end

    // Receive FSM with the bit-period counter, bit index, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_q <= S_START;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q <= '0;
                        if (!rx_s) begin
                            state_q <= S_DATA;
                            idx_q   <= 3'd0;
                        end else begin
                            // The line went high again before mid-start, so treat it as a glitch.
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q          <= '0;
                        shift_q[idx_q] <= rx_s;
                        if (idx_q == 3'd7) begin
                            state_q <= S_STOP;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            rx_data_q  <= shift_q;
                            rx_valid_q <= 1'b1;
                            state_q    <= S_IDLE;
                            busy_q     <= 1'b0;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_WAIT_HIGH;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    // A held-low break stays here and reports only the one frame error.
                    if (rx_s) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_err   = frame_err_q;
    assign busy        = busy_q;
    assign state_dbg_o = state_q;

endmodule
